// File: rtl/ctrl_pkg.sv
// Shared types and constants for the hard-wired control sequencer: states,
// opcodes, ALU codes, datapath enable/bus-select bit positions and decode helpers.
package ctrl_pkg;

  localparam int NUM_EN = 32;
  localparam int ALU_W  = 5;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
  localparam opcode_t OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7;
  localparam opcode_t OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
  localparam opcode_t OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15;
  localparam opcode_t OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
  localparam opcode_t OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam opcode_t OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'd3, ALU_AND = 5'd5, ALU_OR = 5'd6, ALU_INC_PC = 5'd14;

  localparam int EN_R15 = 15, EN_HI = 16, EN_LO = 17, EN_Z = 18, EN_Y = 19, EN_PC = 20;
  localparam int EN_MDR = 21, EN_OUTPORT = 22, EN_CON = 23, EN_IR = 24, EN_MAR = 25;

  localparam int BS_HI = 16, BS_LO = 17, BS_ZHI = 18, BS_ZLO = 19, BS_PC = 20;
  localparam int BS_MDR = 21, BS_INPORT = 22, BS_C = 23;

  typedef struct packed {
    logic [NUM_EN-1:0] enable;
    logic [NUM_EN-1:0] bus_select;
    logic [ALU_W-1:0]  alu_op;
    logic gra, grb, grc, rin, rout, baout;
    logic md_read, read_ram, write_ram, run;
  } ctrl_out_t;

  function automatic logic [ALU_W-1:0] alu_code(opcode_t op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: return op;
      default: return '0;
    endcase
  endfunction

  // Final execute step of each instruction; anything unlisted is a one-step T3 op.
  function automatic state_t last_step(opcode_t op);
    case (op)
      OP_LD, OP_ST: return ST_T7;
      OP_MUL, OP_DIV, OP_BR: return ST_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI: return ST_T5;
      OP_NEG, OP_NOT, OP_JAL: return ST_T4;
      default: return ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control bundle between sequencer and datapath. Defining CTRL_MEM_WAIT_EN
// adds the mem_ready input used to stretch RAM steps.
interface ctrl_sequencer_if;
  import ctrl_pkg::*;

  logic [31:0]       ir;
  logic              con_ff;
  logic [NUM_EN-1:0] enable;
  logic [NUM_EN-1:0] bus_select;
  logic [ALU_W-1:0]  alu_op;
  logic gra, grb, grc, rin, rout, baout;
  logic md_read, read_ram, write_ram, run;
`ifdef CTRL_MEM_WAIT_EN
  logic mem_ready;

  modport master (input ir, con_ff, mem_ready,
                  output enable, bus_select, alu_op, gra, grb, grc, rin, rout, baout,
                         md_read, read_ram, write_ram, run);
  modport slave  (output ir, con_ff, mem_ready,
                  input enable, bus_select, alu_op, gra, grb, grc, rin, rout, baout,
                        md_read, read_ram, write_ram, run);
`else
  modport master (input ir, con_ff,
                  output enable, bus_select, alu_op, gra, grb, grc, rin, rout, baout,
                         md_read, read_ram, write_ram, run);
  modport slave  (output ir, con_ff,
                  input enable, bus_select, alu_op, gra, grb, grc, rin, rout, baout,
                        md_read, read_ram, write_ram, run);
`endif
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the current step and latched opcode (plus con_ff
// for the branch) onto every datapath control strobe.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t    state,
  input  opcode_t   opcode,
  input  logic      con_ff,
  output ctrl_out_t ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      ST_T0: begin
        ctl.run = 1'b1;
        ctl.bus_select[BS_PC] = 1'b1;
        ctl.enable[EN_MAR] = 1'b1;
        ctl.enable[EN_Z] = 1'b1;
        ctl.alu_op = ALU_INC_PC;
      end
      ST_T1: begin
        ctl.run = 1'b1;
        ctl.bus_select[BS_ZLO] = 1'b1;
        ctl.enable[EN_PC] = 1'b1;
        ctl.enable[EN_MDR] = 1'b1;
        ctl.md_read = 1'b1;
        ctl.read_ram = 1'b1;
      end
      ST_T2: begin
        ctl.run = 1'b1;
        ctl.bus_select[BS_MDR] = 1'b1;
        ctl.enable[EN_IR] = 1'b1;
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        ctl.run = 1'b1;
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin
            case (state)
              ST_T3: begin ctl.grb = 1'b1; ctl.baout = 1'b1; ctl.enable[EN_Y] = 1'b1; end
              ST_T4: begin ctl.bus_select[BS_C] = 1'b1; ctl.alu_op = ALU_ADD; ctl.enable[EN_Z] = 1'b1; end
              ST_T5: begin
                ctl.bus_select[BS_ZLO] = 1'b1;
                if (opcode == OP_LDI) begin ctl.gra = 1'b1; ctl.rin = 1'b1; end
                else ctl.enable[EN_MAR] = 1'b1;
              end
              ST_T6: begin
                ctl.enable[EN_MDR] = 1'b1;
                if (opcode == OP_LD) begin ctl.md_read = 1'b1; ctl.read_ram = 1'b1; end
                else begin ctl.gra = 1'b1; ctl.rout = 1'b1; end
              end
              ST_T7: begin
                if (opcode == OP_LD) begin
                  ctl.bus_select[BS_MDR] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
                end else ctl.write_ram = 1'b1;
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state)
              ST_T3: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_Y] = 1'b1; end
              ST_T4: begin
                if (opcode >= OP_ADDI) ctl.bus_select[BS_C] = 1'b1;
                else begin ctl.grc = 1'b1; ctl.rout = 1'b1; end
                ctl.alu_op = alu_code(opcode);
                ctl.enable[EN_Z] = 1'b1;
              end
              ST_T5: begin ctl.bus_select[BS_ZLO] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (state)
              ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_Y] = 1'b1; end
              ST_T4: begin
                ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.alu_op = alu_code(opcode); ctl.enable[EN_Z] = 1'b1;
              end
              ST_T5: begin ctl.bus_select[BS_ZLO] = 1'b1; ctl.enable[EN_LO] = 1'b1; end
              ST_T6: begin ctl.bus_select[BS_ZHI] = 1'b1; ctl.enable[EN_HI] = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            if (state == ST_T3) begin
              ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.alu_op = alu_code(opcode); ctl.enable[EN_Z] = 1'b1;
            end else if (state == ST_T4) begin
              ctl.bus_select[BS_ZLO] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
            end
          end
          OP_BR: begin
            case (state)
              ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_CON] = 1'b1; end
              ST_T4: begin ctl.bus_select[BS_PC] = 1'b1; ctl.enable[EN_Y] = 1'b1; end
              ST_T5: begin ctl.bus_select[BS_C] = 1'b1; ctl.alu_op = ALU_ADD; ctl.enable[EN_Z] = 1'b1; end
              ST_T6: begin ctl.bus_select[BS_ZLO] = 1'b1; ctl.enable[EN_PC] = con_ff; end
              default: ;
            endcase
          end
          OP_JR:  if (state == ST_T3) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_PC] = 1'b1; end
          OP_JAL: begin
            if (state == ST_T3) begin
              ctl.bus_select[BS_PC] = 1'b1; ctl.enable[EN_R15] = 1'b1;
            end else if (state == ST_T4) begin
              ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_PC] = 1'b1;
            end
          end
          OP_IN:   begin ctl.bus_select[BS_INPORT] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
          OP_OUT:  begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.enable[EN_OUTPORT] = 1'b1; end
          OP_MFHI: begin ctl.bus_select[BS_HI] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
          OP_MFLO: begin ctl.bus_select[BS_LO] = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hard-wired control unit: fetch T0-T2, opcode latch, execute T3-T7, HALT.
// Defining CTRL_MEM_WAIT_EN makes RAM steps wait for bus.mem_ready.
module ctrl_sequencer
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic clr,
  ctrl_sequencer_if.master bus
);

  state_t    state, next_state;
  opcode_t   opcode;
  ctrl_out_t ctl;
  logic      advance;
  logic      unused_ir;

  assign unused_ir = ^bus.ir[26:0];

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .con_ff (bus.con_ff),
    .ctl    (ctl)
  );

`ifdef CTRL_MEM_WAIT_EN
  assign advance = bus.mem_ready || !(ctl.read_ram || ctl.write_ram);
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_RST:  next_state = ST_T0;
      ST_T0:   next_state = ST_T1;
      ST_T1:   next_state = ST_T2;
      ST_T2:   next_state = ST_T3;
      ST_HALT: next_state = ST_HALT;
      ST_T3, ST_T4, ST_T5, ST_T6: begin
        if (state == last_step(opcode))
          next_state = (opcode == OP_HALT) ? ST_HALT : ST_T0;
        else
          next_state = state_t'(state + 4'd1);
      end
      default: next_state = ST_T0;
    endcase
  end

  // The opcode is captured on the edge that leaves T2, so it is valid from T3 on.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= ST_RST;
      opcode <= '0;
    end else if (advance) begin
      state <= next_state;
      if (state == ST_T2) opcode <= bus.ir[31:27];
    end
  end

  assign bus.enable     = ctl.enable;
  assign bus.bus_select = ctl.bus_select;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.gra        = ctl.gra;
  assign bus.grb        = ctl.grb;
  assign bus.grc        = ctl.grc;
  assign bus.rin        = ctl.rin;
  assign bus.rout       = ctl.rout;
  assign bus.baout      = ctl.baout;
  assign bus.md_read    = ctl.md_read;
  assign bus.read_ram   = ctl.read_ram;
  assign bus.write_ram  = ctl.write_ram;
  assign bus.run        = ctl.run;

  bus_onehot: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus.bus_select));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: an instruction-level model queues the
// expected per-cycle control word, a negedge monitor pops and compares.
module tb_ctrl_sequencer;

  localparam int E_R15 = 15, E_HI = 16, E_LO = 17, E_Z = 18, E_Y = 19, E_PC = 20;
  localparam int E_MDR = 21, E_OUTP = 22, E_CON = 23, E_IR = 24, E_MAR = 25;
  localparam int B_HI = 16, B_LO = 17, B_ZHI = 18, B_ZLO = 19, B_PC = 20;
  localparam int B_MDR = 21, B_INP = 22, B_C = 23;

  localparam logic [9:0] F_GRA = 10'h001, F_GRB = 10'h002, F_GRC = 10'h004, F_RIN = 10'h008;
  localparam logic [9:0] F_ROUT = 10'h010, F_BAOUT = 10'h020, F_MDRD = 10'h040;
  localparam logic [9:0] F_RD = 10'h080, F_WR = 10'h100, F_RUN = 10'h200;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  alu;
    logic [9:0]  fl;
  } vec_t;

  typedef struct {
    vec_t v;
    int   op;
    int   idx;
  } item_t;

  logic  clk, clr;
  bit    mon_on;
  int    total, bad;
  item_t sb[$];
  vec_t  plan[$];

  ctrl_sequencer_if bus_if();

  ctrl_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(int e1, int e2, int b, int alu, logic [9:0] fl);
    vec_t r;
    r = '0;
    if (e1 >= 0) r.en[e1] = 1'b1;
    if (e2 >= 0) r.en[e2] = 1'b1;
    if (b >= 0) r.bs[b] = 1'b1;
    r.alu = 5'(alu);
    r.fl = fl | F_RUN;
    return r;
  endfunction

  function automatic vec_t actual();
    vec_t r;
    r.en  = bus_if.enable;
    r.bs  = bus_if.bus_select;
    r.alu = bus_if.alu_op;
    r.fl  = {bus_if.run, bus_if.write_ram, bus_if.read_ram, bus_if.md_read, bus_if.baout,
             bus_if.rout, bus_if.rin, bus_if.grc, bus_if.grb, bus_if.gra};
    return r;
  endfunction

  // Instruction-level model: the full cycle-by-cycle control word list for one instruction.
  task automatic plan_instr(input int op, input bit con, input int stall);
    plan.delete();
    plan.push_back(mk(E_MAR, E_Z, B_PC, 14, 10'h0));
    for (int k = 0; k <= stall; k++) plan.push_back(mk(E_PC, E_MDR, B_ZLO, 0, F_MDRD | F_RD));
    plan.push_back(mk(E_IR, -1, B_MDR, 0, 10'h0));
    if (op >= 3 && op <= 14) begin
      plan.push_back(mk(E_Y, -1, -1, 0, F_GRB | F_ROUT));
      if (op <= 11) plan.push_back(mk(E_Z, -1, -1, op, F_GRC | F_ROUT));
      else plan.push_back(mk(E_Z, -1, B_C, (op == 12) ? 3 : (op == 13) ? 5 : 6, 10'h0));
      plan.push_back(mk(-1, -1, B_ZLO, 0, F_GRA | F_RIN));
    end else begin
      case (op)
        0, 1, 2: begin
          plan.push_back(mk(E_Y, -1, -1, 0, F_GRB | F_BAOUT));
          plan.push_back(mk(E_Z, -1, B_C, 3, 10'h0));
          if (op == 1) plan.push_back(mk(-1, -1, B_ZLO, 0, F_GRA | F_RIN));
          else plan.push_back(mk(E_MAR, -1, B_ZLO, 0, 10'h0));
          if (op == 0) begin
            plan.push_back(mk(E_MDR, -1, -1, 0, F_MDRD | F_RD));
            plan.push_back(mk(-1, -1, B_MDR, 0, F_GRA | F_RIN));
          end else if (op == 2) begin
            plan.push_back(mk(E_MDR, -1, -1, 0, F_GRA | F_ROUT));
            plan.push_back(mk(-1, -1, -1, 0, F_WR));
          end
        end
        15, 16: begin
          plan.push_back(mk(E_Y, -1, -1, 0, F_GRA | F_ROUT));
          plan.push_back(mk(E_Z, -1, -1, op, F_GRB | F_ROUT));
          plan.push_back(mk(E_LO, -1, B_ZLO, 0, 10'h0));
          plan.push_back(mk(E_HI, -1, B_ZHI, 0, 10'h0));
        end
        17, 18: begin
          plan.push_back(mk(E_Z, -1, -1, op, F_GRB | F_ROUT));
          plan.push_back(mk(-1, -1, B_ZLO, 0, F_GRA | F_RIN));
        end
        19: begin
          plan.push_back(mk(E_CON, -1, -1, 0, F_GRA | F_ROUT));
          plan.push_back(mk(E_Y, -1, B_PC, 0, 10'h0));
          plan.push_back(mk(E_Z, -1, B_C, 3, 10'h0));
          plan.push_back(mk(con ? E_PC : -1, -1, B_ZLO, 0, 10'h0));
        end
        20: plan.push_back(mk(E_PC, -1, -1, 0, F_GRA | F_ROUT));
        21: begin
          plan.push_back(mk(E_R15, -1, B_PC, 0, 10'h0));
          plan.push_back(mk(E_PC, -1, -1, 0, F_GRA | F_ROUT));
        end
        22: plan.push_back(mk(-1, -1, B_INP, 0, F_GRA | F_RIN));
        23: plan.push_back(mk(E_OUTP, -1, -1, 0, F_GRA | F_ROUT));
        24: plan.push_back(mk(-1, -1, B_HI, 0, F_GRA | F_RIN));
        25: plan.push_back(mk(-1, -1, B_LO, 0, F_GRA | F_RIN));
        default: plan.push_back(mk(-1, -1, -1, 0, 10'h0));
      endcase
    end
    if (op == 27) repeat (20) plan.push_back(vec_t'(0));
  endtask

  task automatic checkOutput(input string name, input vec_t want);
    vec_t got;
    got = actual();
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got en=%h bs=%h alu=%0d fl=%h, want en=%h bs=%h alu=%0d fl=%h",
               name, got.en, got.bs, got.alu, got.fl, want.en, want.bs, want.alu, want.fl);
    end
  endtask

  // Called one time unit after the edge that starts T0; queues up to 'keep' cycles.
  task automatic applyStimulus(input logic [31:0] word, input bit con, input int stall,
                               input int keep, output int n);
    int op;
    op = int'(word[31:27]);
    plan_instr(op, con, stall);
    n = (keep > 0 && keep < plan.size()) ? keep : plan.size();
    for (int i = 0; i < n; i++) sb.push_back('{v: plan[i], op: op, idx: i});
    bus_if.ir = word;
    bus_if.con_ff = con;
`ifdef CTRL_MEM_WAIT_EN
    bus_if.mem_ready = (stall == 0);
`endif
  endtask

  task automatic run_for(input int n, input int stall);
    if (stall > 0) begin
      repeat (1 + stall) @(posedge clk);
      #1;
`ifdef CTRL_MEM_WAIT_EN
      bus_if.mem_ready = 1'b1;
`endif
      repeat (n - 1 - stall) @(posedge clk);
    end else begin
      repeat (n) @(posedge clk);
    end
    #1;
  endtask

  task automatic instr(input logic [31:0] word, input bit con, input int stall);
    int n;
    applyStimulus(word, con, stall, 0, n);
    run_for(n, stall);
  endtask

  task automatic pulse_reset();
    mon_on = 1'b0;
    clr = 1'b0;
    #2 checkOutput("reset_zero", vec_t'(0));
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_flush: got %0d pending, want 0", sb.size());
      sb.delete();
    end
    #2 clr = 1'b1;
    @(posedge clk);
    #1 mon_on = 1'b1;
  endtask

  always @(negedge clk) begin
    item_t it;
    if (mon_on && clr) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL underflow: DUT cycle with no expected entry, got en=%h", bus_if.enable);
      end else begin
        it = sb.pop_front();
        checkOutput($sformatf("op%0d_step%0d", it.op, it.idx), it.v);
      end
    end
  end

  initial begin
    int n, op, st;
    logic [31:0] w;
    total = 0;
    bad = 0;
    mon_on = 1'b0;
    clr = 1'b0;
    bus_if.ir = '0;
    bus_if.con_ff = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    bus_if.mem_ready = 1'b1;
`endif
    #10 checkOutput("in_reset_a", vec_t'(0));
    #10 checkOutput("in_reset_b", vec_t'(0));
    #5 clr = 1'b1;
    @(posedge clk);
    #1 mon_on = 1'b1;

    instr(32'h18918000, 1'b0, 0);
    instr({5'd19, 27'h0123456}, 1'b0, 0);
    instr({5'd19, 27'h0123456}, 1'b1, 0);
    instr({5'd2, 27'h0456789}, 1'b0, 0);

    // ld aborted by reset while in T5
    applyStimulus({5'd0, 27'h0222222}, 1'b0, 0, 6, n);
    repeat (5) @(posedge clk);
    #7 pulse_reset();

    for (int i = 0; i < 50; i++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      w = $urandom;
      w[31:27] = op[4:0];
      st = 0;
`ifdef CTRL_MEM_WAIT_EN
      st = int'($urandom_range(0, 2));
`endif
      instr(w, 1'($urandom), st);
    end

`ifdef CTRL_MEM_WAIT_EN
    instr(32'h18918000, 1'b0, 3);
`endif

    instr({5'd27, 27'h0}, 1'b0, 0);
    pulse_reset();
    instr({5'd21, 27'h0333333}, 1'b0, 0);
    instr({5'd12, 27'h0444444}, 1'b0, 0);

    mon_on = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Hard-wired control unit that drives the existing datapath's control inputs from IR contents.
- Runs the fetch steps T0–T2, decodes the opcode in IR[31:27], then runs that instruction's execute steps T3–T7.
- Sits directly above the datapath. Its outputs connect one-to-one to the datapath enable/bus-select/ALU-op/register-select/RAM strobes.
- Replaces bench-driven sequencing.

Parameters:
- NUM_EN, 32, width of enable and bus_select vectors.
- ALU_W, 5, width of alu_op.

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset; asynchronous, active-low.
- ir  in  32  instruction register contents from datapath.
- con_ff  in  1  branch condition flip-flop output.
- enable  out  NUM_EN  register load enables.
- bus_select  out  NUM_EN  one-hot bus source select.
- alu_op  out  ALU_W  ALU operation code.
- gra, grb, grc  out  1  select IR ra/rb/rc field for register-select logic.
- rin, rout, baout  out  1  selected-register in/out/base-address out.
- md_read  out  1  MDR source = memory.
- read_ram, write_ram  out  1  RAM strobes.
- run  out  1  high while executing; low in reset and HALT.

Behaviour:
- Enable bit map (package constants):
  - R0–R15 in = 0–15, HIin 16, LOin 17, Zin 18, Yin 19, PCin 20.
  - MDRin 21, OutPortin 22, CONin 23, IRin 24, MARin 25.
- Bus-select bit map: R0–R15 out = 0–15, HIout 16, LOout 17, ZHIout 18, ZLOout 19, PCout 20, MDRout 21, InPortout 22, Cout 23.
- States: RST, T0–T7, HALT. Exactly one state per clock. Moore outputs decoded from registered state plus latched opcode. Any signal not listed for a step is 0.
- Reset (clr=0, async): state=RST, all outputs 0, run=0. First edge after release goes to T0. Reset mid-instruction aborts immediately with no partial strobes.
- Opcode is latched at the end of T2; it is undefined before then.
- Fetch:
  - T0: PCout, MARin, alu_op=INC_PC(14), Zin.
  - T1: ZLOout, PCin, MDRin, md_read, read_ram.
  - T2: MDRout, IRin.
- Opcodes: 0 ld, 1 ldi, 2 st, 3 add, 4 sub, 5 and, 6 or, 7 shr, 8 shra, 9 shl, 10 ror, 11 rol, 12 addi, 13 andi, 14 ori, 15 mul, 16 div, 17 neg, 18 not, 19 br, 20 jr, 21 jal, 22 in, 23 out, 24 mfhi, 25 mflo, 26 nop, 27 halt. Opcodes 28–31 execute as nop.
- ALU codes: alu_op=opcode for 3–11 and 15–18. addi→3, andi→5, ori→6.
- Execute steps (last listed step returns to T0):
  - R-type: T3 grb rout Yin; T4 grc rout alu_op Zin; T5 ZLOout gra rin.
  - Immediate: T3 grb rout Yin; T4 Cout alu_op Zin; T5 ZLOout gra rin.
  - ldi: T3 grb baout Yin; T4 Cout alu_op=3 Zin; T5 ZLOout gra rin.
  - ld: as ldi through T4; T5 ZLOout MARin; T6 md_read read_ram MDRin; T7 MDRout gra rin.
  - st: as ld through T5; T6 gra rout MDRin (md_read=0); T7 write_ram.
  - mul/div: T3 gra rout Yin; T4 grb rout alu_op Zin; T5 ZLOout LOin; T6 ZHIout HIin.
  - neg/not: T3 grb rout alu_op Zin; T4 ZLOout gra rin.
  - br: T3 gra rout CONin; T4 PCout Yin; T5 Cout alu_op=3 Zin; T6 ZLOout, plus PCin only if con_ff=1.
  - jr: T3 gra rout PCin.
  - jal: T3 PCout, enable[15]; T4 gra rout PCin.
  - in: T3 InPortout gra rin.
  - out: T3 gra rout OutPortin.
  - mfhi: T3 HIout gra rin.
  - mflo: T3 LOout gra rin.
  - nop: T3 with no strobes.
  - halt: T3→HALT. HALT holds all outputs 0 and run=0 until reset.
- bus_select is always one-hot or zero. A two-hot bus_select is a design error; an assertion checks it.

Optional Feature:
CTRL_MEM_WAIT_EN
- With the macro: adds input mem_ready (1 bit). Steps asserting read_ram or write_ram (fetch T1, ld T6, st T7) repeat while mem_ready=0, with all outputs held stable. The step advances on the first edge where mem_ready=1. Reset during a wait aborts immediately.
- Without the macro: the port is absent and every step lasts exactly one cycle.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALU code constants (including INC_PC=14);
  - enable/bus-select bit-index constants;
  - the opcode→alu_op function.
- One sub-module, ctrl_decode: combinational decode of {state, opcode, con_ff} to outputs. The top keeps the state register, opcode latch, and wait logic.

Test Plan:
- Reset released at 25 ns → all outputs 0 while clr=0. At the first clk edge after release, state=T0 and enable[25]=enable[18]=bus_select[20]=1 with alu_op=14.
- ir=0x18918000 (add r1,r2,r3) → T3–T5 produce grb/rout/Yin, then grc/rout/alu_op=3/Zin, then ZLOout/gra/rin; next cycle is T0. Total instruction length 6 cycles.
- br with con_ff=0 then con_ff=1 → T6 asserts enable[20] only in the con_ff=1 run; bus_select[19]=1 in both runs.
- st (opcode 2) → write_ram=1 only in T7, and md_read=0 in T6.
- halt (opcode 27) → run falls after T3 and outputs stay 0 for 20 cycles. clr pulsed low mid-ld (in T5) → outputs clear immediately and fetch restarts.
- With CTRL_MEM_WAIT_EN and mem_ready held low 3 cycles in fetch T1 → T1 outputs are stable for 4 cycles, then T2.
